// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU operation sequencer
//
// Purpose: opcode codes understood by the downstream 4-bit ALU, the
// sequencer FSM state encoding and the default datapath width.
// Ports: none (package).
package alu_pkg;

  localparam int DW_DEFAULT = 4;

  // ALU_Sel codes, passed straight through to the ALU
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  // Sequencer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, ALU and response signals of the sequencer
//
// Purpose: bundles the command channel (cmd_*), the ALU operand/result
// wires (alu_*) and the response channel (rsp_*).
// Modports: slave  - the sequencer itself
//           master - the environment (command source, ALU, response sink)
interface alu_op_sequencer_if #(
  parameter int DW    = 4,
  parameter int NREGS = 4
);

  localparam int IW = $clog2(NREGS);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_ld;
  logic [2:0]    cmd_op;
  logic [IW-1:0] cmd_rd;
  logic [IW-1:0] cmd_rs1;
  logic [IW-1:0] cmd_rs2;
  logic [DW-1:0] cmd_imm;

  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [2:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_cout;
  logic          alu_zero;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_cout;
  logic          rsp_zero;

  modport slave (
    input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  alu_out, alu_cout, alu_zero, rsp_ready,
    output cmd_ready, alu_x, alu_y, alu_sel,
    output rsp_valid, rsp_data, rsp_cout, rsp_zero
  );

  modport master (
    output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output alu_out, alu_cout, alu_zero, rsp_ready,
    input  cmd_ready, alu_x, alu_y, alu_sel,
    input  rsp_valid, rsp_data, rsp_cout, rsp_zero
  );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x DW register file, two async reads, one sync write
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all regs)
//   rd_addr1/rd_data1    combinational read port 1
//   rd_addr2/rd_data2    combinational read port 2
//   wr_en/wr_addr/wr_data synchronous write port
module alu_regfile #(
  parameter  int DW    = 4,
  parameter  int NREGS = 4,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_addr1,
  output logic [DW-1:0] rd_data1,
  input  logic [IW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data2,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs [NREGS];

  // Reset wins over a same-cycle write, so an aborted writeback is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - register-file front end feeding and draining the 4-bit ALU
//
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of alu_op_sequencer_if:
//        cmd_*  command in (valid/ready), load-immediate or ALU op
//        alu_*  registered operands/select out, ALU result/flags in
//        rsp_*  result of the command out (valid/ready)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int DW    = DW_DEFAULT,
  parameter  int NREGS = 4,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  logic [1:0]    state;
  logic [IW-1:0] rd_q;
  logic [DW-1:0] alu_x_q;
  logic [DW-1:0] alu_y_q;
  logic [2:0]    alu_sel_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_cout_q;
  logic          rsp_zero_q;

  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          accept;

  assign accept = (state == ST_IDLE) && bus.cmd_valid;

  // Two writers share the one port: an accepted load in IDLE, or the ALU
  // result at the end of EXEC. They can never coincide.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.cmd_rd;
    wr_data = bus.cmd_imm;
    if (state == ST_EXEC) begin
      wr_en   = 1'b1;
      wr_addr = rd_q;
      wr_data = bus.alu_out;
    end else if (accept && bus.cmd_ld) begin
      wr_en   = 1'b1;
    end
  end

  alu_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (bus.cmd_rs1),
    .rd_data1 (rs1_data),
    .rd_addr2 (bus.cmd_rs2),
    .rd_data2 (rs2_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_q       <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_sel_q  <= '0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q <= bus.cmd_rd;
            if (bus.cmd_ld) begin
              rsp_data_q <= bus.cmd_imm;
              rsp_cout_q <= 1'b0;
              rsp_zero_q <= (bus.cmd_imm == '0);
              state      <= ST_RESP;
            end else begin
              // Operands sampled now, so rd aliasing rs1/rs2 sees old values
              alu_x_q   <= rs1_data;
              alu_y_q   <= rs2_data;
              alu_sel_q <= bus.cmd_op;
              state     <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_data_q <= bus.alu_out;
          rsp_cout_q <= bus.alu_cout;
          rsp_zero_q <= bus.alu_zero;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DW    = 4;
  localparam int NREGS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DW(DW), .NREGS(NREGS)) bus ();

  alu_op_sequencer #(.DW(DW), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 4-bit ALU behaviour: 5-bit arithmetic, logic ops leave carry clear
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      OP_ADD:  return {1'b0, x} + {1'b0, y};
      OP_SUB:  return {1'b0, x} - {1'b0, y};
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_NAND: return {1'b0, ~(x & y)};
      OP_XOR:  return {1'b0, x ^ y};
      OP_XNOR: return {1'b0, ~(x ^ y)};
      default: return {1'b0, ~(x | y)};
    endcase
  endfunction

  // The ALU that sits beside the sequencer
  logic [4:0] alu_r;
  always_comb begin
    alu_r        = alu_ref(bus.alu_sel, bus.alu_x, bus.alu_y);
    bus.alu_out  = alu_r[3:0];
    bus.alu_cout = alu_r[4];
    bus.alu_zero = (alu_r[3:0] == 4'd0);
  end

  // Transaction-level model: which command is in flight and what it returns
  logic [3:0] m_regs [NREGS];
  bit         m_idle, m_wait, m_valid;
  logic [3:0] m_data, m_x, m_y;
  logic       m_cout, m_zero;
  logic [2:0] m_sel;
  logic [1:0] m_rd;
  logic [4:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 4'd0;
      m_idle = 1; m_wait = 0; m_valid = 0;
      m_data = 0; m_cout = 0; m_zero = 0;
      m_x = 0; m_y = 0; m_sel = 0; m_rd = 0; m_res = 0;
    end else if (m_idle) begin
      if (bus.cmd_valid) begin
        m_idle = 0;
        if (bus.cmd_ld) begin
          m_regs[bus.cmd_rd] = bus.cmd_imm;
          m_data  = bus.cmd_imm;
          m_cout  = 0;
          m_zero  = (bus.cmd_imm == 4'd0);
          m_valid = 1;
        end else begin
          m_x    = m_regs[bus.cmd_rs1];
          m_y    = m_regs[bus.cmd_rs2];
          m_sel  = bus.cmd_op;
          m_rd   = bus.cmd_rd;
          m_res  = alu_ref(m_sel, m_x, m_y);
          m_wait = 1;
        end
      end
    end else if (m_wait) begin
      m_regs[m_rd] = m_res[3:0];
      m_data  = m_res[3:0];
      m_cout  = m_res[4];
      m_zero  = (m_res[3:0] == 4'd0);
      m_wait  = 0;
      m_valid = 1;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 0;
      m_idle  = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_cmd_ready", bus.cmd_ready, m_idle);
      check("cmp_rsp_valid", bus.rsp_valid, m_valid);
      check("cmp_alu_x", bus.alu_x, m_x);
      check("cmp_alu_y", bus.alu_y, m_y);
      check("cmp_alu_sel", bus.alu_sel, m_sel);
      if (m_valid) begin
        check("cmp_rsp_data", bus.rsp_data, m_data);
        check("cmp_rsp_cout", bus.rsp_cout, m_cout);
        check("cmp_rsp_zero", bus.rsp_zero, m_zero);
      end
    end
  end

  task automatic send(input bit ld, input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input logic [3:0] imm, output int acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = ld;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.cmd_ready) begin
        #1;
        acc = cyc;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (acc < 0) check("send_timeout", 0, 1);
  endtask

  task automatic do_cmd(input string nm, input bit ld, input logic [2:0] op,
                        input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [3:0] imm, input logic [3:0] ed, input logic ec, input logic ez);
    int acc;
    int k;
    send(ld, op, rd, rs1, rs2, imm, acc);
    k = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        k = cyc;
        break;
      end
    end
    if (k < 0) begin
      check({nm, "_rsp_timeout"}, 0, 1);
    end else begin
      check({nm, "_latency"}, k + 1 - acc, ld ? 1 : 2);
      check({nm, "_data"}, bus.rsp_data, ed);
      check({nm, "_cout"}, bus.rsp_cout, ec);
      check({nm, "_zero"}, bus.rsp_zero, ez);
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] op_d [8] = '{4'b0110, 4'b0010, 4'b1000, 4'b1110, 4'b0111, 4'b0110, 4'b1001, 4'b0001};
  logic       op_c [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int acc;
    int seen;
    bus.cmd_valid = 0; bus.cmd_ld = 0; bus.cmd_op = 0;
    bus.cmd_rd = 0; bus.cmd_rs1 = 0; bus.cmd_rs2 = 0; bus.cmd_imm = 0;
    bus.rsp_ready = 1;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_cout", bus.rsp_cout, 0);
    check("rst_rsp_zero", bus.rsp_zero, 0);
    check("rst_alu_x", bus.alu_x, 0);
    check("rst_alu_y", bus.alu_y, 0);
    check("rst_alu_sel", bus.alu_sel, 0);

    // Load then add with overflow to zero; r2 reads back as 0
    do_cmd("ld_r0_9", 1, 0, 0, 0, 0, 4'd9, 4'd9, 0, 0);
    do_cmd("ld_r1_7", 1, 0, 1, 0, 0, 4'd7, 4'd7, 0, 0);
    do_cmd("add_r2", 0, OP_ADD, 2, 0, 1, 0, 4'b0000, 1, 1);
    do_cmd("add_r3_r2", 0, OP_ADD, 3, 2, 0, 0, 4'd9, 0, 0);

    // Subtract with borrow
    do_cmd("ld_r0_3", 1, 0, 0, 0, 0, 4'd3, 4'd3, 0, 0);
    do_cmd("ld_r1_5", 1, 0, 1, 0, 0, 4'd5, 4'd5, 0, 0);
    do_cmd("sub_r3", 0, OP_SUB, 3, 0, 1, 0, 4'b1110, 1, 0);

    // Logic and aliasing
    do_cmd("ld_r0_a", 1, 0, 0, 0, 0, 4'b1010, 4'b1010, 0, 0);
    do_cmd("ld_r1_6", 1, 0, 1, 0, 0, 4'b0110, 4'b0110, 0, 0);
    do_cmd("xor_alias", 0, OP_XOR, 0, 0, 1, 0, 4'b1100, 0, 0);
    do_cmd("nand_alias", 0, OP_NAND, 1, 0, 1, 0, 4'b1011, 0, 0);
    do_cmd("ld_zero", 1, 0, 3, 0, 0, 4'd0, 4'd0, 0, 1);

    // Backpressure: response held, commands ignored
    bus.rsp_ready = 0;
    send(1, 0, 2, 0, 0, 4'd5, acc);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("bp_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.cmd_valid = (i % 2 == 0);
      bus.cmd_ld = 0; bus.cmd_op = OP_ADD; bus.cmd_rd = 3; bus.cmd_rs1 = 2; bus.cmd_rs2 = 2;
      @(negedge clk);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 4'd5);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 0;
    bus.rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", bus.cmd_ready, 1);
    check("bp_release_valid", bus.rsp_valid, 0);
    do_cmd("bp_r2_kept", 0, OP_OR, 3, 2, 2, 0, 4'd5, 0, 0);

    // Reset on the EXEC edge discards the writeback
    do_cmd("ld_r0_2", 1, 0, 0, 0, 0, 4'd2, 4'd2, 0, 0);
    do_cmd("ld_r1_3", 1, 0, 1, 0, 0, 4'd3, 4'd3, 0, 0);
    do_cmd("ld_r2_0", 1, 0, 2, 0, 0, 4'd0, 4'd0, 0, 1);
    send(0, OP_ADD, 2, 0, 1, 0, acc);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rstx_rsp_valid", bus.rsp_valid, 0);
    check("rstx_cmd_ready", bus.cmd_ready, 1);
    check("rstx_rsp_data", bus.rsp_data, 0);
    do_cmd("rstx_r2_zero", 0, OP_OR, 3, 2, 2, 0, 4'd0, 0, 1);

    // All eight opcodes, X=1100 Y=1010
    do_cmd("ld_r0_c", 1, 0, 0, 0, 0, 4'b1100, 4'b1100, 0, 0);
    do_cmd("ld_r1_a", 1, 0, 1, 0, 0, 4'b1010, 4'b1010, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'(i);
      do_cmd($sformatf("op%0d", i), 0, op, 2, 0, 1, 0, op_d[i], op_c[i], op_d[i] == 4'd0);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Register-file front end for the 4-bit ALU. It accepts ALU and load-immediate commands over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU's X/Y/ALU_Sel inputs, captures ALU_Out/Cout/Zero one cycle later, writes the result back, and returns it on a valid/ready response channel. It sits directly upstream of the ALU, which it feeds, and directly downstream of it, since it consumes the ALU's outputs.

## Interface
Parameters:
- DW, 4, data width; must equal ALU operand width.
- NREGS, 4, register count; register index width is $clog2(NREGS) (2 at default).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_ld  in  1  1 = load immediate, 0 = ALU op
- cmd_op  in  3  ALU select code, ignored when cmd_ld=1
- cmd_rd  in  2  destination register index
- cmd_rs1  in  2  source 1 register index, drives X
- cmd_rs2  in  2  source 2 register index, drives Y
- cmd_imm  in  DW  immediate value for load
- alu_x  out  DW  to ALU X
- alu_y  out  DW  to ALU Y
- alu_sel  out  3  to ALU ALU_Sel
- alu_out  in  DW  from ALU ALU_Out
- alu_cout  in  1  from ALU Cout
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DW  result written to rd
- rsp_cout  out  1  carry/borrow of the result (0 for loads)
- rsp_zero  out  1  rsp_data == 0

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On a handshake with cmd_ld=1: write regs[rd]=cmd_imm; load rsp_data=cmd_imm, rsp_cout=0, rsp_zero=(cmd_imm==0); go to RESP.
  - On a handshake with cmd_ld=0: register alu_x=regs[rs1], alu_y=regs[rs2], alu_sel=cmd_op; latch rd; go to EXEC.
- EXEC: the ALU is combinational. At the end of the cycle:
  - capture alu_out, alu_cout and alu_zero into rsp_data, rsp_cout and rsp_zero;
  - write regs[rd]=alu_out;
  - go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_cout and rsp_zero are held stable until rsp_ready=1, then the FSM returns to IDLE.
- cmd_ready=0 in EXEC and RESP; no command is accepted while one is in flight.
- Operands are read at accept time, so rd==rs1 or rd==rs2 uses the old value. The writeback is visible to the next command.
- alu_x, alu_y and alu_sel hold their last values outside EXEC; they do not return to 0.
- Arithmetic is the ALU's: 5-bit result, so SUB reports the borrow in cout. The block does no width extension of its own.
- cmd_op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NAND, 101 XOR, 110 XNOR, 111 NOR.

## Timing
- Reset values: state=IDLE, all regs=0, cmd_ready=1 (once rst deasserts), rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_zero=0, alu_x=0, alu_y=0, alu_sel=000.
- ALU op latency: accepted at edge N, EXEC during cycle N+1, rsp_valid high after edge N+2.
- Load latency: accepted at edge N, rsp_valid high after edge N+1.
- Throughput with rsp_ready tied high: one ALU op per 3 cycles, one load per 2 cycles.
- Backpressure: RESP is held indefinitely while rsp_ready=0, with outputs stable.
- Simultaneous cmd_valid during RESP: ignored, because cmd_ready=0. The upstream holds the command.
- Reset mid-operation (EXEC or RESP): the in-flight command is discarded. No writeback occurs if rst is high on the EXEC edge. All outputs take their reset values on the next edge.
- Register index 0 is an ordinary register, not hardwired to zero.

## Structure
- Shared package alu_pkg:
  - opcode localparams OP_ADD through OP_NOR, using the codes above;
  - FSM state encoding (2-bit, IDLE=0, EXEC=1, RESP=2);
  - DW default.
- One sub-module, alu_regfile: NREGS x DW, two combinational read ports, one synchronous write port, synchronous reset to zero.
- The FSM, operand registers and response registers live in alu_op_sequencer.
- The ALU is instantiated beside this block in the enclosing top level, not inside it.

## Test plan
- Load then add: LD r0=9, LD r1=7, ADD r2=r0+r1 -> rsp_data=0000, rsp_cout=1, rsp_zero=1; r2 reads back 0 on the next command.
- Subtract with borrow: r0=3, r1=5, SUB r3=r0-r1 -> rsp_data=1110, rsp_cout=1, rsp_zero=0. Response appears exactly 2 edges after accept.
- Logic and aliasing:
  - r0=1010, r1=0110, XOR r0=r0^r1 -> 1100;
  - then NAND r1=r0&r1 (old r0 overwritten) -> 1011.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, and cmd_valid pulses are ignored (cmd_ready=0). Release -> IDLE next cycle.
- Reset mid-EXEC: ADD r2 in flight, rst high on the EXEC edge -> r2 stays 0, rsp_valid=0, cmd_ready=1 after reset.
- All eight opcodes with X=1100, Y=1010 -> expected values:
  - ADD 0110, cout 1
  - SUB 0010, cout 0
  - AND 1000
  - OR 1110
  - NAND 0111
  - XOR 0110
  - XNOR 1001
  - NOR 0001
